// File: rtl/mac_pipe_if.sv
// mac_pipe_if: operand/result bundle for the pipelined multiply-add/accumulate unit
interface mac_pipe_if #(
  parameter int SIZE_IN  = 8,
  parameter int SIZE_OUT = 20
);
  logic                in_valid;
  logic                mode;
  logic                acc_clear;
  logic [SIZE_IN-1:0]  A;
  logic [SIZE_IN-1:0]  B;
  logic [SIZE_IN-1:0]  C;
  logic [SIZE_OUT-1:0] Umm;
  logic [SIZE_OUT-1:0] data_out;
  logic                out_valid;
  logic                sat;
  modport master (
    output in_valid, mode, acc_clear, A, B, C,
    input  Umm, data_out, out_valid, sat
  );
  modport slave (
    input  in_valid, mode, acc_clear, A, B, C,
    output Umm, data_out, out_valid, sat
  );
endinterface

// File: rtl/mac_pipe.sv
// mac_pipe: two-stage A*B+C / saturating A*B accumulate pipeline
module mac_pipe #(
  parameter int SIZE_IN  = 8,
  parameter int SIZE_OUT = 20,
  parameter bit SIGNED   = 0
) (
  input logic       clock,
  input logic       reset,
  mac_pipe_if.slave bus
);
  localparam int PW = 2*SIZE_IN+1;
  localparam int EW = 2*SIZE_IN+2;
  localparam int W  = SIZE_OUT+2;
  localparam logic signed [W-1:0] ONE = 1;
  localparam logic signed [W-1:0] HI  = SIGNED ? (ONE <<< (SIZE_OUT-1)) - ONE : (ONE <<< SIZE_OUT) - ONE;
  localparam logic signed [W-1:0] LO  = SIGNED ? -(ONE <<< (SIZE_OUT-1)) : '0;
  if (SIZE_OUT < 2*SIZE_IN+1) begin : g_bad_width
    $error("mac_pipe: SIZE_OUT must be at least 2*SIZE_IN+1");
  end
  function automatic logic signed [EW-1:0] ext_in(input logic [SIZE_IN-1:0] v);
    return SIGNED ? EW'($signed(v)) : EW'(v);
  endfunction
  function automatic logic signed [W-1:0] ext_out(input logic [SIZE_OUT-1:0] v);
    return SIGNED ? W'($signed(v)) : W'(v);
  endfunction
  logic signed [PW-1:0] prod;
  logic [SIZE_IN-1:0]   c_d;
  logic                 mode_d, clr_d, v1;
  logic [SIZE_OUT-1:0]  acc, c_x, add, res;
  logic signed [W-1:0]  sum;
  logic                 over, under;
  // the product always fits in 2*SIZE_IN+1 signed bits, so sign extension also serves the unsigned case
  always_comb prod = PW'(ext_in(bus.A) * ext_in(bus.B));
  // result select: plain add for mode 0 and seeds, clamped running sum otherwise
  always_comb begin
    c_x   = SIGNED ? SIZE_OUT'($signed(c_d)) : SIZE_OUT'(c_d);
    add   = bus.Umm + c_x;
    sum   = ext_out(acc) + ext_out(bus.Umm);
    over  = sum > HI;
    under = sum < LO;
    res   = (mode_d && !clr_d) ? (over ? HI[SIZE_OUT-1:0] : under ? LO[SIZE_OUT-1:0] : sum[SIZE_OUT-1:0]) : add;
  end
  // stage 1: register product and carry C/mode/acc_clear alongside it
  always_ff @(posedge clock)
    if (reset) begin
      v1      <= 1'b0;
      bus.Umm <= '0;
      c_d     <= '0;
      mode_d  <= 1'b0;
      clr_d   <= 1'b0;
    end else begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        bus.Umm <= SIZE_OUT'(prod);
        c_d     <= bus.C;
        mode_d  <= bus.mode;
        clr_d   <= bus.acc_clear;
      end
    end
  // stage 2: publish result; only mode-1 samples touch the accumulator and sticky flag
  always_ff @(posedge clock)
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.data_out  <= '0;
      bus.sat       <= 1'b0;
      acc           <= '0;
    end else begin
      bus.out_valid <= v1;
      if (v1) begin
        bus.data_out <= res;
        if (mode_d) begin
          acc     <= res;
          bus.sat <= clr_d ? 1'b0 : (bus.sat | over | under);
        end
      end
    end
endmodule

// File: tb/tb_mac_pipe.sv
// tb_mac_pipe: unsigned and signed instances checked against an integer reference model
module tb_mac_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  always #5 clk = ~clk;
  mac_pipe_if #(.SIZE_IN(8), .SIZE_OUT(20)) ui ();
  mac_pipe_if #(.SIZE_IN(8), .SIZE_OUT(20)) si ();
  mac_pipe #(.SIZE_IN(8), .SIZE_OUT(20), .SIGNED(0)) u_dut (.clock(clk), .reset(rst), .bus(ui.slave));
  mac_pipe #(.SIZE_IN(8), .SIZE_OUT(20), .SIGNED(1)) s_dut (.clock(clk), .reset(rst), .bus(si.slave));
  longint      acc_m [2];
  logic        sat_m [2];
  logic        pv    [2];
  logic [19:0] pd    [2];
  logic        ps    [2];
  logic [19:0] e_umm [2];
  logic [19:0] e_dout[2];
  logic        e_ov  [2];
  logic        e_sat [2];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  function automatic longint xv(input logic [7:0] x, input int sg);
    return sg != 0 ? longint'($signed(x)) : longint'(x);
  endfunction
  task automatic step(input logic r, input logic v, input logic m, input logic cl,
                      input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    longint p, rv, hi, lo;
    logic   clip;
    rst = r;
    ui.in_valid = v; ui.mode = m; ui.acc_clear = cl; ui.A = a; ui.B = b; ui.C = c;
    si.in_valid = v; si.mode = m; si.acc_clear = cl; si.A = a; si.B = b; si.C = c;
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      hi = g != 0 ? 524287 : 1048575;
      lo = g != 0 ? -524288 : 0;
      if (r) begin
        acc_m[g] = 0; sat_m[g] = 1'b0; pv[g] = 1'b0;
        e_umm[g] = '0; e_dout[g] = '0; e_ov[g] = 1'b0; e_sat[g] = 1'b0;
      end else begin
        e_ov[g] = pv[g];
        if (pv[g]) begin
          e_dout[g] = pd[g];
          e_sat[g]  = ps[g];
        end
        pv[g] = v;
        if (v) begin
          p = xv(a, g) * xv(b, g);
          e_umm[g] = p[19:0];
          clip = 1'b0;
          if (!m || cl) rv = p + xv(c, g);
          else begin
            rv = acc_m[g] + p;
            if (rv > hi) begin rv = hi; clip = 1'b1; end
            if (rv < lo) begin rv = lo; clip = 1'b1; end
          end
          if (m) begin
            acc_m[g] = rv;
            sat_m[g] = cl ? 1'b0 : (sat_m[g] | clip);
          end
          pd[g] = rv[19:0];
          ps[g] = sat_m[g];
        end
      end
    end
    check("u.umm",  32'(ui.Umm),       32'(e_umm[0]));
    check("u.dout", 32'(ui.data_out),  32'(e_dout[0]));
    check("u.ov",   32'(ui.out_valid), 32'(e_ov[0]));
    check("u.sat",  32'(ui.sat),       32'(e_sat[0]));
    check("s.umm",  32'(si.Umm),       32'(e_umm[1]));
    check("s.dout", 32'(si.data_out),  32'(e_dout[1]));
    check("s.ov",   32'(si.out_valid), 32'(e_ov[1]));
    check("s.sat",  32'(si.sat),       32'(e_sat[1]));
  endtask
  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask
  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    check("rst_dout", 32'(ui.data_out), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 8'd4, 8'd5);
    check("basic_umm", 32'(ui.Umm), 32'd12);
    idle();
    check("basic_dout", 32'(ui.data_out), 32'd17);
    check("basic_ov", 32'(ui.out_valid), 32'd1);
    idle();
    check("basic_ov_end", 32'(ui.out_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd255, 8'd255, 8'd255);
    idle();
    check("ext_dout", 32'(ui.data_out), 32'd65280);
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    idle();
    idle();
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 8'd3, 8'd10);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 8'd3, 8'd0);
    check("chain16", 32'(ui.data_out), 32'd16);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 8'd3, 8'd0);
    check("chain22", 32'(ui.data_out), 32'd22);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 8'd1);
    check("chain28", 32'(ui.data_out), 32'd28);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1, 8'd0);
    check("mode0_2", 32'(ui.data_out), 32'd2);
    idle();
    check("chain29", 32'(ui.data_out), 32'd29);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255);
    for (int i = 1; i <= 18; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'd255, 8'd255, 8'd0);
      if (i == 16) begin
        check("sat15_dout", 32'(ui.data_out), 32'd1040655);
        check("sat15_flag", 32'(ui.sat), 32'd0);
      end
      if (i == 17) begin
        check("sat16_dout", 32'(ui.data_out), 32'd1048575);
        check("sat16_flag", 32'(ui.sat), 32'd1);
      end
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0);
    check("sat_hold", 32'(ui.data_out), 32'd1048575);
    idle();
    check("clr_dout", 32'(ui.data_out), 32'd0);
    check("clr_sat", 32'(ui.sat), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'hFD, 8'h04, 8'hFE);
    idle();
    check("sgn_dout", 32'(si.data_out), 32'h0_FFFF2);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h80, 8'h7F, 8'h80);
    repeat (34) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h80, 8'h7F, 8'h00);
    idle();
    check("neg_sat_dout", 32'(si.data_out), 32'h0_80000);
    check("neg_sat_flag", 32'(si.sat), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 8'd4, 8'd5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    check("rst_mid_umm", 32'(ui.Umm), 32'd0);
    check("rst_mid_sat", 32'(ui.sat), 32'd0);
    idle();
    check("rst_mid_ov", 32'(ui.out_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'd7, 8'd7, 8'd7);
    idle();
    check("rst_drop_ov", 32'(ui.out_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 8'd4, 8'd5);
    idle();
    check("post_rst_dout", 32'(ui.data_out), 32'd17);
    repeat (400)
      step($urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
           8'($urandom), 8'($urandom), 8'($urandom));
    idle();
    idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mac_pipe.md
# mac_pipe

Parametrised two-stage pipelined multiply-add/accumulate unit. Computes A*B+C (mode 0) or a running saturating accumulation of A*B (mode 1). Operands are qualified by a valid strobe and results by a matching output strobe. Sits in the arithmetic datapath wherever a fixed A*B+C pipe is too narrow or needs dot-product accumulation.

## Interface

Parameters:
- SIZE_IN, default 8: operand width of A, B and C.
- SIZE_OUT, default 20: result width. Elaboration must fail if SIZE_OUT < 2*SIZE_IN+1.
- SIGNED, default 0: selects operand and result representation. 0 = unsigned; 1 = two's complement.

Ports:
- clock, in, 1: sole clock. All logic updates on the rising edge.
- reset, in, 1: synchronous, active-high.
- in_valid, in, 1: A, B, C, mode and acc_clear are sampled on an edge where in_valid=1.
- mode, in, 1: 0 = multiply-add; 1 = accumulate.
- acc_clear, in, 1: meaningful only in mode 1. Seeds the accumulator with C instead of its current value.
- A, in, SIZE_IN: multiplicand.
- B, in, SIZE_IN: multiplier.
- C, in, SIZE_IN: addend (mode 0) or accumulator seed (mode 1 with acc_clear).
- Umm, out, SIZE_OUT: registered product A*B from stage 1, zero- or sign-extended.
- data_out, out, SIZE_OUT: registered result from stage 2.
- out_valid, out, 1: data_out holds a new result this cycle.
- sat, out, 1: sticky accumulator saturation flag.

## Operation

- Stage 1, on an edge with in_valid=1:
  - Umm ← A*B at full width.
  - C, mode and acc_clear are delayed alongside it.
  - The stage-1 valid bit ← in_valid, every edge.
- Stage 2, on an edge with the stage-1 valid bit set, result is selected as:
  - mode 0: Umm + C_d. The accumulator is untouched. Never overflows, given the SIZE_OUT rule.
  - mode 1, acc_clear=1: Umm + C_d. The accumulator ← result. sat ← 0.
  - mode 1, acc_clear=0: sat(acc + Umm). The accumulator ← result.
- Saturation in mode 1 with acc_clear=0:
  - Overflow clamps to the maximum: 2^SIZE_OUT−1 unsigned; 2^(SIZE_OUT−1)−1 signed.
  - Signed underflow clamps to −2^(SIZE_OUT−1).
  - Any clamp sets sat=1. sat holds until reset or an accepted acc_clear.
- data_out ← result and out_valid ← 1 on the same edge.
- Stage 2 reads the accumulator register value from before the edge. Back-to-back mode-1 samples chain correctly with no bubble and no forwarding hazard.
- Bubbles: when in_valid=0, the corresponding stage registers hold their values. out_valid=0 for that slot. data_out and Umm keep their last values.
- Mode 1 with acc_clear=0 before any seed accumulates onto the current accumulator contents (0 after reset).
- Modes may be interleaved freely. Mode-0 samples never disturb the accumulator or sat.

## Timing

- Latency is 2 edges. For a sample accepted at edge n:
  - Umm updates at edge n.
  - data_out and out_valid update at edge n+1.
- Throughput is one sample per cycle. out_valid mirrors the in_valid pattern delayed by 2 edges.
- No backpressure: a consumer must accept every out_valid.
- Reset values: Umm=0, data_out=0, out_valid=0, sat=0, accumulator=0, all valid bits=0.
- Reset has priority over all other inputs.
- Reset asserted mid-pipeline discards every in-flight sample. No out_valid pulse may appear for those samples.
- A sample presented on an edge where reset=1 is discarded.
- The first sample can be accepted on the first edge with reset=0.

## Test plan

All scenarios use SIZE_IN=8, SIZE_OUT=20.

- **Mode 0, unsigned basic:** SIGNED=0, A=3, B=4, C=5, mode=0, one valid cycle → Umm=12 one edge later; data_out=17 with a single out_valid pulse two edges later; sat=0.
- **Mode 0, unsigned extremes:** A=B=C=255, mode=0 → data_out=65280. Also verify 5 back-to-back mode-0 samples produce 5 consecutive out_valid cycles.
- **Accumulate chain:** A=2, B=3, C=10, mode=1, acc_clear=1, then two samples A=2, B=3, acc_clear=0, all contiguous → data_out 16, 22, 28 on three consecutive valid cycles. Then insert a mode-0 sample 1*1+1 → data_out 2; a following accumulate of 1*1 → 29.
- **Saturation:** seed with 255*255+255 = 65280, then 16 accumulates of 255*255 → 15th result 1040655, sat=0; 16th result 1048575, sat=1. A further accumulate stays at 1048575 with sat=1. A subsequent acc_clear seed with A=B=C=0 → data_out 0, sat=0.
- **Signed:** SIGNED=1, A=0xFD (−3), B=0x04, C=0xFE (−2), mode=0 → data_out 20'hFFFF2 (−14). Also negative saturation: seed with −128*127+(−128) = −16384, then accumulate −128*127 = −16256 repeatedly → clamps at 20'h80000 (−524288) with sat=1.
- **Reset mid-pipeline:** accept A=3, B=4, C=5; assert reset for one cycle at the next edge → out_valid never pulses for that sample; Umm=0, data_out=0, sat=0. A sample presented after reset releases completes normally at 2-edge latency.
